serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//  Parametrised multi-cycle adder/subtractor: processes WIDTH-bit operands DIGIT bits per clock, LSB first.
//  Built from a chain of 1-bit add/sub cells plus carry/borrow register; mode selects a+b+cin or a-b-bin.
//  Valid/ready on both sides; sits as shared arithmetic engine in datapaths needing area over speed.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=1)
//  DIGIT  1  bits processed per cycle; WIDTH % DIGIT == 0 required (elaboration error otherwise)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      operands/mode/cin present
//  in_ready   out  1      engine idle, can accept
//  a          in   WIDTH  minuend / augend
//  b          in   WIDTH  subtrahend / addend
//  mode       in   1      0 = add, 1 = subtract
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  out_valid  out  1      result fields valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  sum / difference mod 2^WIDTH
//  cout       out  1      carry-out (add) / borrow-out (sub)
//  ovf        out  1      two's-complement signed overflow
//  zero       out  1      result == 0
// BEHAVIOUR
//  Single clock; rst_n asynchronous active-low. Reset: state IDLE, in_ready=1, out_valid=0,
//   result=0, cout=0, ovf=0, zero=0, step counter=0; operands/carry regs cleared. Inputs ignored while rst_n=0.
//  FSM: IDLE -(in_valid&in_ready)-> RUN -(last step)-> DONE -(out_ready)-> IDLE.
//  IDLE: in_ready=1. On accept latch a,b,mode,cin; carry reg = cin; step=0. Inputs need not stay stable after.
//  RUN: STEPS=WIDTH/DIGIT cycles; each cycle DIGIT cells consume low DIGIT bits of a/b shift regs;
//   sum bits shifted into result from MSB end; carry reg <- cell chain out. in_ready=0.
//  Cell add: s=a^b^c, c'=a&b | c&(a^b). Cell sub: d=a^b^c, c'=~a&b | ~(a^b)&c (c = borrow).
//  DONE: out_valid=1; result, cout, ovf, zero held stable until out_ready sampled high; in_ready=0.
//  Latency: accept at edge k -> out_valid=1 after edge k+STEPS; DIGIT==WIDTH gives 1 RUN cycle.
//  ovf add: a[MSB]==b[MSB] && result[MSB]!=a[MSB]; sub: a[MSB]!=b[MSB] && result[MSB]!=a[MSB].
//  zero, ovf, cout computed on entry to DONE and registered; not valid outside DONE.
//  DONE & out_ready: returns to IDLE next edge; in_valid same cycle ignored (in_ready=0); no overlap.
//  out_valid falls the edge after handshake; result regs keep last value (not cleared).
//  rst_n low mid-RUN/DONE: in-flight op discarded, no out_valid pulse, all regs to reset values.
//  WIDTH=1 DIGIT=1 sub mode reproduces the 1-bit full subtractor truth table (diff, bout).
// STRUCTURE
//  Shared package add_sub_pkg: MODE_ADD=1'b0, MODE_SUB=1'b1; state encodings ST_IDLE/ST_RUN/ST_DONE (2-bit).
//  Sub-module add_sub_cell (a, b, c_in, mode -> s, c_out), instantiated DIGIT times in a generate chain.
//  Top holds FSM, $clog2(STEPS+1)-bit step counter, operand shift regs, carry reg, result reg, flag regs.
// TESTING
//  T1 W=8 D=1: add 0x7F+0x01 cin=0 -> result 0x80 cout=0 ovf=1 zero=0; out_valid 8 cycles after accept.
//  T2 W=8 D=1: sub 0x00-0x01 bin=0 -> 0xFF cout(borrow)=1 ovf=0; sub 0x80-0x01 -> 0x7F cout=0 ovf=1.
//  T3 W=1 D=1: sub all 8 (a,b,bin) combos -> diff/bout match full-subtractor table, e.g. 0,1,1 -> 0,1.
//  T4 W=8 D=4: sub 0x55-0x55 bin=0 -> 0x00 zero=1 cout=0; latency 2; add 0xFF+0x00 cin=1 -> 0x00 cout=1.
//  T5 backpressure: hold out_ready=0 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored;
//     raise out_ready -> out_valid low next edge, in_ready=1, next op accepted, correct result.
//  T6 rst_n low at RUN step 3 (W=8 D=1) -> out_valid=0 in_ready=1 at once; no result emitted; next op correct.

Source files
------------

// File: rtl/add_sub_pkg.sv
// -----------------------------------------------------------------------------
// add_sub_pkg
//   Shared definitions for the serial adder/subtractor engine.
//   - MODE_ADD / MODE_SUB : encoding of the 'mode' input
//   - state_t             : FSM state encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package add_sub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_cell.sv
// -----------------------------------------------------------------------------
// add_sub_cell
//   One-bit full adder / full subtractor.
//   Ports:
//     a, b   : operand bits
//     c_in   : carry-in (add) or borrow-in (sub)
//     mode   : MODE_ADD or MODE_SUB
//     s      : sum / difference bit
//     c_out  : carry-out (add) or borrow-out (sub)
// -----------------------------------------------------------------------------
module add_sub_cell
  import add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c_in,
  input  logic mode,
  output logic s,
  output logic c_out
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign s       = a_xor_b ^ c_in;

  always_comb begin
    c_out = 1'b0;
    if (mode == MODE_SUB) begin
      // Borrow out when b exceeds a, or when equal bits must pass a borrow on.
      c_out = (~a & b) | (~a_xor_b & c_in);
    end else begin
      c_out = (a & b) | (c_in & a_xor_b);
    end
  end

endmodule

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//   Multi-cycle adder/subtractor processing DIGIT bits per clock, LSB first.
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high; the producer holds its fields while valid is high and ready
//   low, the consumer may change ready freely.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid / in_ready : operand handshake (in_ready high only when idle)
//     a, b, mode, cin     : operands, 0=add 1=sub, carry/borrow in
//     out_valid/out_ready : result handshake (out_valid high only in DONE)
//     result, cout        : sum/difference mod 2^WIDTH, carry/borrow out
//     ovf, zero           : signed overflow, result==0 (registered on DONE entry)
// -----------------------------------------------------------------------------
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS  = WIDTH / DIGIT;
  localparam int STEP_W = $clog2(STEPS + 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_add_sub: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  state_t            state, state_n;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  a_sr, b_sr, res_sr;
  logic              mode_q, carry_q, a_msb, b_msb;

  logic [DIGIT:0]    chain;
  logic [DIGIT-1:0]  sum_d;
  logic [WIDTH-1:0]  res_next;
  logic              last_step, ovf_next;

  // Ripple chain over the low DIGIT bits of the operand shift registers.
  assign chain[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    add_sub_cell u_cell (
      .a     (a_sr[i]),
      .b     (b_sr[i]),
      .c_in  (chain[i]),
      .mode  (mode_q),
      .s     (sum_d[i]),
      .c_out (chain[i+1])
    );
  end

  // New digit enters at the MSB end; after STEPS shifts the LSB digit sits at bit 0.
  assign res_next  = (res_sr >> DIGIT) | (WIDTH'(sum_d) << (WIDTH - DIGIT));
  assign last_step = (step == STEP_W'(STEPS - 1));

  always_comb begin
    ovf_next = 1'b0;
    if (mode_q == MODE_SUB) begin
      ovf_next = (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
    end else begin
      ovf_next = (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (in_valid)  state_n = ST_RUN;
      ST_RUN:  if (last_step) state_n = ST_DONE;
      ST_DONE: if (out_ready) state_n = ST_IDLE;
      default:                state_n = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      step    <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr    <= a;
            b_sr    <= b;
            mode_q  <= mode;
            carry_q <= cin;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
            step    <= '0;
          end
        end
        ST_RUN: begin
          a_sr    <= a_sr >> DIGIT;
          b_sr    <= b_sr >> DIGIT;
          carry_q <= chain[DIGIT];
          res_sr  <= res_next;
          step    <= step + STEP_W'(1);
          // Visible outputs only change when the full result is known.
          if (last_step) begin
            result <= res_next;
            cout   <= chain[DIGIT];
            ovf    <= ovf_next;
            zero   <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
//   Three engines: u0 (W=8,D=1), u1 (W=1,D=1), u2 (W=8,D=4).
//   Expected values come from signed/unsigned integer arithmetic on the
//   operands; inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

  logic clk;
  logic rst_n;

  logic       iv   [3];
  logic       ordy [3];
  logic [7:0] av   [3];
  logic [7:0] bv   [3];
  logic       mdv  [3];
  logic       civ  [3];
  logic       irdy [3];
  logic       ov   [3];
  logic       co   [3];
  logic       of   [3];
  logic       zr   [3];
  logic [7:0] rs   [3];
  logic [7:0] rs_0, rs_2;
  logic       rs_1;

  int n_vec = 0;
  int n_err = 0;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(av[0]), .b(bv[0]), .mode(mdv[0]), .cin(civ[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(rs_0),
    .cout(co[0]), .ovf(of[0]), .zero(zr[0])
  );

  serial_add_sub #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(av[1][0:0]), .b(bv[1][0:0]), .mode(mdv[1]), .cin(civ[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(rs_1),
    .cout(co[1]), .ovf(of[1]), .zero(zr[1])
  );

  serial_add_sub #(.WIDTH(8), .DIGIT(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(av[2]), .b(bv[2]), .mode(mdv[2]), .cin(civ[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .result(rs_2),
    .cout(co[2]), .ovf(of[2]), .zero(zr[2])
  );

  assign rs[0] = rs_0;
  assign rs[1] = {7'b0, rs_1};
  assign rs[2] = rs_2;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wid_of(input int u);
    return (u == 1) ? 1 : 8;
  endfunction

  function automatic int steps_of(input int u);
    return (u == 0) ? 8 : (u == 1) ? 1 : 2;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input int x, input int y, input bit sub,
                                input bit c, output int r, output bit c_o,
                                output bit v_o, output bit z_o);
    int m, full, sx, sy, sr;
    m  = 1 << w;
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    if (sub) begin
      full = x - y - int'(c);
      sr   = sx - sy - int'(c);
      c_o  = (full < 0);
      r    = (full + 2 * m) % m;
    end else begin
      full = x + y + int'(c);
      sr   = sx + sy + int'(c);
      c_o  = (full >= m);
      r    = full % m;
    end
    v_o = (sr > m / 2 - 1) || (sr < -(m / 2));
    z_o = (r == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver + scoreboard for one operation, with 'hold' cycles of backpressure.
  task automatic run_op(input int u, input int x_in, input int y_in, input bit sub,
                        input bit c, input int hold);
    int x, y, r, n;
    bit e_c, e_v, e_z;
    x = x_in & ((1 << wid_of(u)) - 1);
    y = y_in & ((1 << wid_of(u)) - 1);
    model(wid_of(u), x, y, sub, c, r, e_c, e_v, e_z);

    @(negedge clk);
    chk("in_ready_idle", 32'(irdy[u]), 32'd1);
    iv[u]  = 1'b1;
    av[u]  = 8'(x);
    bv[u]  = 8'(y);
    mdv[u] = sub;
    civ[u] = c;
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) begin
        // Inputs are don't-care once accepted.
        iv[u]  = 1'b0;
        av[u]  = 8'($urandom);
        bv[u]  = 8'($urandom);
        mdv[u] = 1'($urandom);
        civ[u] = 1'($urandom);
      end
      n++;
    end while (!ov[u] && n < 40);

    chk("latency", 32'(n - 1), 32'(steps_of(u)));
    chk("result", 32'(rs[u]), 32'(r));
    chk("cout", 32'(co[u]), 32'(e_c));
    chk("ovf", 32'(of[u]), 32'(e_v));
    chk("zero", 32'(zr[u]), 32'(e_z));
    chk("in_ready_done", 32'(irdy[u]), 32'd0);

    for (int h = 0; h < hold; h++) begin
      iv[u]   = 1'b1;
      av[u]   = 8'($urandom);
      bv[u]   = 8'($urandom);
      ordy[u] = 1'b0;
      @(negedge clk);
      chk("hold_valid", 32'(ov[u]), 32'd1);
      chk("hold_in_ready", 32'(irdy[u]), 32'd0);
      chk("hold_result", 32'(rs[u]), 32'(r));
      chk("hold_flags", {29'd0, co[u], of[u], zr[u]}, {29'd0, e_c, e_v, e_z});
    end

    iv[u]   = 1'b0;
    ordy[u] = 1'b1;
    @(negedge clk);
    ordy[u] = 1'b0;
    chk("out_valid_drop", 32'(ov[u]), 32'd0);
    chk("in_ready_back", 32'(irdy[u]), 32'd1);
    chk("result_kept", 32'(rs[u]), 32'(r));
  endtask

  initial begin
    bit seen;
    for (int u = 0; u < 3; u++) begin
      iv[u] = 0; ordy[u] = 0; av[u] = 0; bv[u] = 0; mdv[u] = 0; civ[u] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // reset state, inputs ignored while in reset
    iv[0] = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_in_ready", 32'(irdy[u]), 32'd1);
      chk("rst_out_valid", 32'(ov[u]), 32'd0);
      chk("rst_result", 32'(rs[u]), 32'd0);
      chk("rst_flags", {29'd0, co[u], of[u], zr[u]}, 32'd0);
    end
    iv[0] = 1'b0;
    rst_n = 1'b1;

    // T1: add with signed overflow, latency 8
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
    // T2: subtract with borrow / with overflow
    run_op(0, 8'h00, 8'h01, 1'b1, 1'b0, 0);
    run_op(0, 8'h80, 8'h01, 1'b1, 1'b0, 0);
    // T3: 1-bit full subtractor and full adder tables
    for (int k = 0; k < 8; k++) run_op(1, (k >> 2) & 1, (k >> 1) & 1, 1'b1, 1'(k), 0);
    for (int k = 0; k < 8; k++) run_op(1, (k >> 2) & 1, (k >> 1) & 1, 1'b0, 1'(k), 0);
    // T4: DIGIT=4, zero flag and carry through all digits
    run_op(2, 8'h55, 8'h55, 1'b1, 1'b0, 0);
    run_op(2, 8'hFF, 8'h00, 1'b0, 1'b1, 0);
    // T5: backpressure for 5 cycles, then a following operation
    run_op(0, 8'h3C, 8'hA5, 1'b0, 1'b1, 5);
    run_op(0, 8'h12, 8'h34, 1'b1, 1'b1, 0);

    // T6: reset at RUN step 3 discards the operation
    @(negedge clk);
    iv[0] = 1'b1; av[0] = 8'h21; bv[0] = 8'h43; mdv[0] = 1'b0; civ[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(ov[0]), 32'd0);
    chk("t6_in_ready", 32'(irdy[0]), 32'd1);
    chk("t6_result", 32'(rs[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    chk("t6_no_output", 32'(seen), 32'd0);
    run_op(0, 8'h21, 8'h43, 1'b0, 1'b0, 0);

    // random operations on every engine
    for (int i = 0; i < 20; i++) begin
      for (int u = 0; u < 3; u++) begin
        run_op(u, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
